// File: rtl/snn_ctrl_if.sv
// Signal bundle between the SNN top-level sequencer and its UART, input RAM and core neighbours.
// The master side belongs to snn_ctrl; the slave side belongs to the surrounding blocks.
interface snn_ctrl_if #(parameter int ADDR_W = 10);
  logic              rx_rdy;
  logic [7:0]        rx_data;
  logic              clr_rx_rdy;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wdata;
  logic              inf_start;
  logic              inf_done;
  logic [3:0]        inf_digit;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_rdy;
  logic [7:0]        led;
  logic              busy;
  logic              ovr;

  modport master (
    input  rx_rdy, rx_data, inf_done, inf_digit, tx_rdy,
    output clr_rx_rdy, ram_we, ram_addr, ram_wdata, inf_start, tx_start, tx_data, led, busy, ovr
  );

  modport slave (
    output rx_rdy, rx_data, inf_done, inf_digit, tx_rdy,
    input  clr_rx_rdy, ram_we, ram_addr, ram_wdata, inf_start, tx_start, tx_data, led, busy, ovr
  );
endinterface

// File: rtl/snn_ctrl.sv
// SNN classifier sequencer: receives a packed image byte-wise, unpacks it LSB-first into the
// input RAM, runs the core, then reports the digit on the LEDs and back over the UART.
module snn_ctrl #(
  parameter int NUM_BYTES = 98,
  parameter int ADDR_W    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  snn_ctrl_if.master    bus
);

  typedef enum logic [2:0] {LOAD, UNPACK, START, WAIT_DONE, TX, TX_WAIT} state_t;

  state_t            state_q, state_d;
  logic [7:0]        byte_q, byte_d;
  logic [6:0]        byte_cnt_q, byte_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              tx_rdy_prev_q;
  logic              clr_q, clr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wdata_q, wdata_d;
  logic              inf_start_q, inf_start_d;
  logic              tx_start_q, tx_start_d;
  logic [3:0]        tx_digit_q, tx_digit_d;
  logic [3:0]        led_digit_q, led_digit_d;
  logic              busy_q, busy_d;
  logic              ovr_q, ovr_d;

  logic       rx_ok;
  logic       leave_wait;
  logic [2:0] bit_nxt;

  // A byte whose clear pulse is already in flight must not be seen a second time.
  assign rx_ok      = bus.rx_rdy && !clr_q;
  assign leave_wait = (state_q == TX_WAIT) && bus.tx_rdy && !tx_rdy_prev_q;
  assign bit_nxt    = bit_cnt_q + 3'd1;

  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    byte_cnt_d  = byte_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    clr_d       = 1'b0;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    inf_start_d = 1'b0;
    tx_start_d  = 1'b0;
    tx_digit_d  = tx_digit_q;
    led_digit_d = led_digit_q;
    ovr_d       = ovr_q;

    case (state_q)
      LOAD: begin
        if (rx_ok) begin
          byte_d    = bus.rx_data;
          clr_d     = 1'b1;
          we_d      = 1'b1;
          addr_d    = ADDR_W'({byte_cnt_q, 3'd0});
          wdata_d   = bus.rx_data[0];
          bit_cnt_d = 3'd0;
          state_d   = UNPACK;
        end
      end
      UNPACK: begin
        // Outputs are registered, so each cycle sets up the write for the following one.
        if (bit_cnt_q == 3'd7) begin
          bit_cnt_d  = 3'd0;
          byte_cnt_d = byte_cnt_q + 7'd1;
          if (byte_cnt_q == 7'(NUM_BYTES - 1)) begin
            state_d     = START;
            inf_start_d = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end else begin
          bit_cnt_d = bit_nxt;
          we_d      = 1'b1;
          addr_d    = ADDR_W'({byte_cnt_q, bit_nxt});
          wdata_d   = byte_q[bit_nxt];
        end
      end
      START: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.inf_done) begin
          tx_digit_d  = bus.inf_digit;
          led_digit_d = bus.inf_digit;
          state_d     = TX;
        end
      end
      TX: begin
        if (bus.tx_rdy) begin
          tx_start_d = 1'b1;
          state_d    = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (leave_wait) begin
          byte_cnt_d = 7'd0;
          state_d    = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase

    // Bytes arriving while the core or transmitter own the frame are dropped and flagged.
    if (rx_ok && (state_q == START || state_q == WAIT_DONE || state_q == TX ||
                  (state_q == TX_WAIT && !leave_wait))) begin
      clr_d = 1'b1;
      ovr_d = 1'b1;
    end

    busy_d = (state_d != LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= LOAD;
      byte_q        <= '0;
      byte_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      tx_rdy_prev_q <= 1'b0;
      clr_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= 1'b0;
      inf_start_q   <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_digit_q    <= '0;
      led_digit_q   <= '0;
      busy_q        <= 1'b0;
      ovr_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_q        <= byte_d;
      byte_cnt_q    <= byte_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      tx_rdy_prev_q <= bus.tx_rdy;
      clr_q         <= clr_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      inf_start_q   <= inf_start_d;
      tx_start_q    <= tx_start_d;
      tx_digit_q    <= tx_digit_d;
      led_digit_q   <= led_digit_d;
      busy_q        <= busy_d;
      ovr_q         <= ovr_d;
    end
  end

  assign bus.clr_rx_rdy = clr_q;
  assign bus.ram_we     = we_q;
  assign bus.ram_addr   = addr_q;
  assign bus.ram_wdata  = wdata_q;
  assign bus.inf_start  = inf_start_q;
  assign bus.tx_start   = tx_start_q;
  assign bus.tx_data    = {4'h0, tx_digit_q};
  assign bus.led        = {4'h0, led_digit_q};
  assign bus.busy       = busy_q;
  assign bus.ovr        = ovr_q;

endmodule

// File: tb/tb_snn_ctrl.sv
// Scoreboard bench for snn_ctrl: frames of random bytes, a simple UART/core environment,
// and a monitor that checks every RAM write and UART transmit against queued expectations.
module tb_snn_ctrl;
  localparam int NB = 98;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snn_ctrl_if #(.ADDR_W(10)) ifc();
  snn_ctrl #(.NUM_BYTES(NB), .ADDR_W(10)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc.master));

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  int start_cnt = 0;
  int tx_cnt = 0;

  logic [7:0]  pend[$];
  logic [10:0] exp_wr[$];
  logic [7:0]  exp_tx[$];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: bit j of frame byte idx lands at RAM address 8*idx+j.
  task automatic push_byte(logic [7:0] b, int idx);
    for (int j = 0; j < 8; j++) exp_wr.push_back({10'(idx * 8 + j), b[j]});
    pend.push_back(b);
  endtask

  // UART receiver model: presents queued bytes, drops rx_rdy when cleared.
  initial begin
    ifc.rx_rdy  = 1'b0;
    ifc.rx_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ifc.rx_rdy = 1'b0;
        pend.delete();
      end else begin
        if (ifc.clr_rx_rdy) ifc.rx_rdy = 1'b0;
        if (!ifc.rx_rdy && pend.size() > 0) begin
          ifc.rx_data = pend.pop_front();
          ifc.rx_rdy  = 1'b1;
        end
      end
    end
  end

  // UART transmitter model: busy for 20 cycles after each start.
  initial begin
    ifc.tx_rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (ifc.tx_start) begin
        ifc.tx_rdy = 1'b0;
        repeat (20) @(negedge clk);
        ifc.tx_rdy = 1'b1;
      end
    end
  end

  // Monitor
  initial begin
    logic [10:0] ew;
    logic [7:0]  et;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ifc.ram_we) begin
          wr_cnt++;
          if (exp_wr.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_write: addr %0d data %0b, none expected", ifc.ram_addr, ifc.ram_wdata);
          end else begin
            ew = exp_wr.pop_front();
            check("ram_write", {ifc.ram_addr, ifc.ram_wdata}, ew);
          end
        end
        if (ifc.inf_start) begin
          start_cnt++;
          check("start_after_last_write", exp_wr.size(), 0);
        end
        if (ifc.tx_start) begin
          tx_cnt++;
          if (exp_tx.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_tx: tx_data %0h, none expected", ifc.tx_data);
          end else begin
            et = exp_tx.pop_front();
            check("tx_data", ifc.tx_data, et);
            check("led_at_tx", ifc.led, et);
          end
        end
      end
    end
  end

  task automatic wait_wr(int target, string name);
    int t = 0;
    while (wr_cnt < target && t < 3000) begin @(negedge clk); t++; end
    check(name, wr_cnt, target);
  endtask

  task automatic serve_core(int prev_starts, logic [3:0] d, bit poke);
    int t = 0;
    while (start_cnt == prev_starts && t < 3000) begin @(negedge clk); t++; end
    check("inf_start_count", start_cnt, prev_starts + 1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (poke && i == 10) pend.push_back(8'h3C);
    end
    ifc.inf_digit = d;
    ifc.inf_done  = 1'b1;
    exp_tx.push_back({4'h0, d});
    @(negedge clk);
    ifc.inf_done  = 1'b0;
  endtask

  task automatic wait_idle(int prev_tx);
    int t = 0;
    while (tx_cnt == prev_tx && t < 500) begin @(negedge clk); t++; end
    check("tx_start_count", tx_cnt, prev_tx + 1);
    t = 0;
    while (ifc.busy && t < 500) begin @(negedge clk); t++; end
    check("return_to_load", ifc.busy, 1'b0);
    check("tx_queue_drained", exp_tx.size(), 0);
  endtask

  function automatic logic [63:0] out_vec();
    return {ifc.ram_we, ifc.ram_addr, ifc.ram_wdata, ifc.clr_rx_rdy, ifc.inf_start,
            ifc.tx_start, ifc.tx_data, ifc.led, ifc.busy, ifc.ovr};
  endfunction

  initial begin
    int t;
    int base;
    logic [3:0] d;
    ifc.inf_done  = 1'b0;
    ifc.inf_digit = 4'h0;

    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), 64'd0);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_outputs", out_vec(), 64'd0);
    check("idle_no_writes", wr_cnt, 0);

    // Frame 1: first byte A5 checked directly, then random bytes.
    push_byte(8'hA5, 0);
    t = 0;
    while (!ifc.ram_we && t < 100) begin @(negedge clk); t++; end
    check("clr_with_first_write", ifc.clr_rx_rdy, 1'b1);
    check("first_addr", ifc.ram_addr, 10'd0);
    check("busy_in_unpack", ifc.busy, 1'b1);
    wait_wr(8, "a5_writes");
    repeat (3) @(negedge clk);
    check("a5_scoreboard_empty", exp_wr.size(), 0);
    check("busy_after_byte", ifc.busy, 1'b0);
    for (int k = 1; k < NB; k++) push_byte(8'($urandom), k);
    wait_wr(NB * 8, "frame1_writes");
    serve_core(0, 4'h9, 1'b0);
    wait_idle(0);
    check("led_frame1", ifc.led, 8'h09);
    check("ovr_clear", ifc.ovr, 1'b0);

    // Frame 2: extra byte pushed while the core runs must be discarded.
    base = wr_cnt;
    for (int k = 0; k < NB; k++) push_byte(8'($urandom), k);
    wait_wr(base + NB * 8, "frame2_writes");
    d = 4'($urandom_range(0, 9));
    serve_core(1, d, 1'b1);
    check("ovr_set", ifc.ovr, 1'b1);
    wait_idle(1);
    repeat (5) @(negedge clk);
    check("ovr_sticky", ifc.ovr, 1'b1);
    check("led_frame2", ifc.led, {4'h0, d});
    check("discard_no_write", wr_cnt, base + NB * 8);

    // Frame 3: aborted by reset after 40 bytes.
    base = wr_cnt;
    for (int k = 0; k < 40; k++) push_byte(8'($urandom), k);
    wait_wr(base + 320, "partial_writes");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("midframe_reset_outputs", out_vec(), 64'd0);
    exp_wr.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Frame 4: must restart at address 0 and complete.
    base = wr_cnt;
    for (int k = 0; k < NB; k++) push_byte(8'($urandom), k);
    wait_wr(base + NB * 8, "frame4_writes");
    d = 4'($urandom_range(0, 15));
    serve_core(2, d, 1'b0);
    wait_idle(2);
    check("led_frame4", ifc.led, {4'h0, d});
    check("ovr_after_reset", ifc.ovr, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/snn_ctrl.md
Name: snn_ctrl

Overview:
Top-level sequencer for the SNN digit classifier. It receives a 98-byte packed image over the UART receiver, unpacks it LSB-first into the 784x1 input image RAM, and launches the neuron core. When the core finishes, it latches the classified digit, shows it on the LEDs and sends it back through the UART transmitter. It sits between uart_rx/uart_tx and the SNN core/input RAM inside snn.

Parameters:
NUM_BYTES, 98, image bytes per frame (NUM_BYTES*8 = image bits).
ADDR_W, 10, input RAM address width.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx_rdy  input  1  uart_rx byte valid, held high until cleared
rx_data  input  8  uart_rx received byte
clr_rx_rdy  output  1  one-cycle pulse that clears rx_rdy in uart_rx
ram_we  output  1  input RAM write enable
ram_addr  output  ADDR_W  input RAM write address
ram_wdata  output  1  input RAM write bit
inf_start  output  1  one-cycle pulse that starts the neuron core
inf_done  input  1  core completion pulse/level; sampled only in WAIT_DONE
inf_digit  input  4  core classification result, valid with inf_done
tx_start  output  1  one-cycle pulse that starts uart_tx
tx_data  output  8  byte to transmit, {4'h0, digit}
tx_rdy  input  1  uart_tx idle/ready
led  output  8  {4'h0, last digit}
busy  output  1  high in any state other than LOAD
ovr  output  1  sticky: a byte was discarded while not in LOAD

Behaviour:
- Reset: all outputs 0; state LOAD; byte_cnt=0; bit_cnt=0; led=0; ovr=0. Reset mid-operation aborts the frame; RAM contents are don't-care.
- All outputs are registered. Pulses are exactly one cycle.
- LOAD: when rx_rdy=1 is sampled at edge N:
  - latch rx_data;
  - clr_rx_rdy=1 during cycle N+1;
  - go to UNPACK.
- UNPACK: 8 cycles, N+1..N+8. Cycle j (0..7) drives ram_we=1, ram_addr=8*byte_cnt+j, ram_wdata=byte[j] (LSB first).
  - After j=7: byte_cnt++.
  - If byte_cnt was NUM_BYTES-1 (last address 783), go to START; otherwise go to LOAD.
  - rx_rdy arriving during UNPACK is not cleared. It is accepted on the first LOAD cycle, so back-to-back bytes are lossless.
- START: inf_start=1 for one cycle; go to WAIT_DONE.
- WAIT_DONE: hold until inf_done=1.
  - Then latch inf_digit into digit; led<={4'h0,inf_digit} on the next cycle; go to TX.
  - There is no timeout.
- TX: tx_data={4'h0,digit}, held from TX entry until the next result.
  - When tx_rdy=1, pulse tx_start and go to TX_WAIT.
  - If tx_rdy=0 on entry, wait in TX.
- TX_WAIT: wait for a tx_rdy 0->1 transition (registered previous value).
  - Then clear byte_cnt; go to LOAD.
- Discard rule: in START/WAIT_DONE/TX/TX_WAIT, rx_rdy=1 causes a clr_rx_rdy pulse. The byte is dropped and ovr is set. ovr clears only on reset.
- led holds its value across frames until overwritten; it is not cleared on a new frame.
- busy = (state != LOAD); it is 1 during UNPACK.
- Simultaneous events:
  - inf_done together with rx_rdy in WAIT_DONE: the done is processed and the byte is discarded (ovr=1).
  - rx_rdy on the same edge as the TX_WAIT->LOAD transition: the byte is taken in LOAD on the next cycle, not discarded.
- Counter widths: byte_cnt 7 bits, bit_cnt 3 bits. The address is computed as {byte_cnt,bit_cnt}, which yields addresses 0..783 only. It never wraps past NUM_BYTES*8-1.

Test Plan:
- Reset with no rx activity for 100 cycles -> all outputs 0, busy=0, no ram_we.
- Send byte 8'hA5 as byte 0 -> clr_rx_rdy one cycle after accept; ram_we for 8 cycles, addr 0..7, wdata 1,0,1,0,0,1,0,1; byte_cnt=1.
- Stream 98 bytes from the sample-9 image file, rx_rdy back-to-back (held during UNPACK) -> 784 writes with addr 0..783 matching the file bits; exactly one inf_start after the write to addr 783.
- Core model asserts inf_done with inf_digit=4'h9, 50 cycles after start -> led=8'h09; one tx_start with tx_data=8'h09 while tx_rdy=1; return to LOAD after tx_rdy rises; second frame restarts at addr 0.
- Push a byte during WAIT_DONE -> clr_rx_rdy pulse, no ram_we, ovr=1 and sticky until rst_n.
- Assert rst_n=0 mid-frame after 40 bytes -> outputs 0 immediately; next frame starts writing at addr 0 and completes normally.
